// File: rtl/led_pattern_seq.sv
// led_pattern_seq: steps an LED_W-bit pattern once per rising edge of the
// slow divider output. The pattern shape comes from mode_i (walk, bounce,
// count, fill), hold_i freezes it, and every mode change reloads the
// shape's start value so each pattern always begins from a legal state.
module led_pattern_seq #(
    parameter int LED_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic [1:0]       mode_i,
    input  logic             hold_i,
    output logic [LED_W-1:0] led_o,
    output logic             step_o
);

    localparam logic [1:0] MODE_WALK   = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_COUNT  = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    localparam logic [LED_W-1:0] LED_ONE  = LED_W'(1);
    localparam logic [LED_W-1:0] LED_ZERO = '0;

    // Bounce travel direction; left means towards the MSB.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // Tick synchroniser / edge detector, mode tracker and pattern state.
    logic             tick_s1_q;
    logic             tick_s2_q;
    logic [1:0]       mode_q;
    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] led_d;
    dir_t             dir_q;
    dir_t             dir_d;
    logic             step_q;
    logic             step_d;

    logic             step_w;
    logic             mode_chg_w;

    // Value each pattern starts from when its mode is entered.
    function automatic logic [LED_W-1:0] start_value(input logic [1:0] mode);
        logic [LED_W-1:0] v;
        case (mode)
            MODE_WALK:   v = LED_ONE;
            MODE_BOUNCE: v = LED_ONE;
            default:     v = LED_ZERO;
        endcase
        return v;
    endfunction

    // Walk: single lit LED rotating towards the MSB, MSB wraps to LSB.
    function automatic logic [LED_W-1:0] next_walk(input logic [LED_W-1:0] cur);
        return {cur[LED_W-2:0], cur[LED_W-1]};
    endfunction

    // Bounce: a turn happens when the lit LED sits at the end it is moving to.
    function automatic logic bounce_turns(input logic [LED_W-1:0] cur, input dir_t dir);
        return (dir == DIR_LEFT) ? cur[LED_W-1] : cur[0];
    endfunction

    // Bounce: at an end the LED steps back inward, otherwise it keeps moving.
    function automatic logic [LED_W-1:0] next_bounce(input logic [LED_W-1:0] cur, input dir_t dir);
        logic [LED_W-1:0] v;
        if (dir == DIR_LEFT) begin
            v = cur[LED_W-1] ? (cur >> 1) : (cur << 1);
        end else begin
            v = cur[0] ? (cur << 1) : (cur >> 1);
        end
        return v;
    endfunction

    // Count: plain binary increment, wrapping naturally at all-ones.
    function automatic logic [LED_W-1:0] next_count(input logic [LED_W-1:0] cur);
        return cur + LED_ONE;
    endfunction

    // Fill: shift a one in from the LSB; a full bank empties on the next step.
    function automatic logic [LED_W-1:0] next_fill(input logic [LED_W-1:0] cur);
        return (&cur) ? LED_ZERO : {cur[LED_W-2:0], 1'b1};
    endfunction

    // A step is requested only on the first cycle the synchronised tick is high,
    // so a long tick high produces exactly one request.
    assign step_w     = tick_s1_q & ~tick_s2_q;
    assign mode_chg_w = (mode_i != mode_q);

    // State register: tick sync chain, mode tracker, pattern, direction, step pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_s1_q <= 1'b0;
            tick_s2_q <= 1'b0;
            mode_q    <= MODE_WALK;
            led_q     <= LED_ONE;
            dir_q     <= DIR_LEFT;
            step_q    <= 1'b0;
        end else begin
            tick_s1_q <= tick_i;
            tick_s2_q <= tick_s1_q;
            mode_q    <= mode_i;
            led_q     <= led_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
        end
    end

    // Next state: a mode change reload outranks a step; hold drops the request.
    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        if (mode_chg_w) begin
            led_d = start_value(mode_i);
            dir_d = DIR_LEFT;
        end else if (step_w && !hold_i) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_WALK: begin
                    led_d = next_walk(led_q);
                end
                MODE_BOUNCE: begin
                    led_d = next_bounce(led_q, dir_q);
                    if (bounce_turns(led_q, dir_q)) begin
                        dir_d = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
                    end
                end
                MODE_COUNT: begin
                    led_d = next_count(led_q);
                end
                MODE_FILL: begin
                    led_d = next_fill(led_q);
                end
                default: begin
                    led_d = led_q;
                end
            endcase
        end
    end

    // Outputs come straight from registers so the LED pins never glitch.
    always_comb begin
        led_o  = led_q;
        step_o = step_q;
    end

endmodule
